// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
package dcache_pkg;
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int TAG_W       = 3;
    localparam int IDX_W       = 3;
    localparam int OFF_W       = 2;
    localparam int BLOCK_W     = 32;

    typedef enum logic [1:0] {IDLE, MEM_WB, MEM_RD, UPDATE} state_e;
endpackage

// File: rtl/dcache_byte_sel.sv
// 4:1 byte-lane mux; offset 0 selects bits [7:0], offset 3 selects bits [31:24].
module dcache_byte_sel (
    input  logic [31:0] block_i,
    input  logic [1:0]  sel_i,
    output logic [7:0]  byte_o
);
    assign byte_o = block_i[{sel_i, 3'b000} +: 8];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache with refill FSM.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT outputs.
module data_cache
    import dcache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    assign {tag, idx, off} = ADDRESS;

    logic [NUM_BLOCKS-1:0]              valid_q, dirty_q;
    logic [NUM_BLOCKS-1:0][TAG_W-1:0]   tag_q;
    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] data_q;
    state_e state_q, state_d;

    logic [BLOCK_W-1:0] line_data;
    logic [TAG_W-1:0]   line_tag;
    logic               req, hit;
    assign line_data = data_q[idx];
    assign line_tag  = tag_q[idx];
    assign req       = READ | WRITE;
    assign hit       = valid_q[idx] && (line_tag == tag);

    logic [7:0] rd_byte;
    dcache_byte_sel u_rd_sel (.block_i(line_data), .sel_i(off), .byte_o(rd_byte));

    // Each lane muxes between its old byte and WRITEDATA; only the lane at 'off' takes the store.
    logic [BLOCK_BYTES-1:0][7:0] merged;
    for (genvar k = 0; k < BLOCK_BYTES; k++) begin : g_lane
        logic [BLOCK_W-1:0] cand;
        always_comb begin
            cand          = {BLOCK_BYTES{line_data[8*k +: 8]}};
            cand[8*k +: 8] = WRITEDATA;
        end
        dcache_byte_sel u_wr_sel (.block_i(cand), .sel_i(off), .byte_o(merged[k]));
    end

    logic        busy, mrd, mwr, refill, serve;
    logic [5:0]  maddr;
    logic [31:0] mwdata;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        mrd     = 1'b0;
        mwr     = 1'b0;
        maddr   = '0;
        mwdata  = '0;
        refill  = 1'b0;
        serve   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        serve = 1'b1;
                    end else begin
                        busy    = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? MEM_WB : MEM_RD;
                    end
                end
            end
            MEM_WB: begin
                busy   = 1'b1;
                mwr    = 1'b1;
                maddr  = {line_tag, idx};
                mwdata = line_data;
                if (!MEM_BUSYWAIT) state_d = MEM_RD;
            end
            MEM_RD: begin
                busy  = 1'b1;
                mrd   = 1'b1;
                maddr = {tag, idx};
                if (!MEM_BUSYWAIT) begin
                    refill  = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while RESET is high so an aborted transaction drops at once.
    assign BUSYWAIT      = busy & ~RESET;
    assign MEM_READ      = mrd & ~RESET;
    assign MEM_WRITE     = mwr & ~RESET;
    assign MEM_ADDRESS   = RESET ? 6'h00 : maddr;
    assign MEM_WRITEDATA = RESET ? 32'h0 : mwdata;
    assign READDATA      = RESET ? 8'h00 : rd_byte;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (refill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (serve && WRITE) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset: an invalid line is never read as a hit.
    always_ff @(posedge CLK) begin
        if (refill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= MEM_READDATA;
        end else if (serve && WRITE) begin
            data_q[idx] <= merged;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        miss_pend_q;
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            miss_pend_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else if (serve) begin
            miss_pend_q <= 1'b0;
            if (miss_pend_q) begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end else begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end
        end else if (state_q == IDLE && req && !hit) begin
            miss_pend_q <= 1'b1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif
endmodule
